// File: rtl/tc_arb_pkg.sv
// Shared types and the round-robin pick function for the 8-way select arbiter.
// The pick is used by tc_rr_pick8 and can be reused by any other rotating selector.
package tc_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {found, idx}. idx is the first set bit at or above ptr, wrapping 7->0.
    // Scanning from the far end lets the closest hit overwrite, so no early exit is needed.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] pos;
        logic [SEL_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (mask[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/tc_rr_pick8.sv
// Combinational round-robin pick over an 8-bit candidate mask.
// Outputs the first set bit searching upward from ptr, plus a found flag.
module tc_rr_pick8
    import tc_arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W:0] pick;

    always_comb begin
        pick  = rr_pick(mask, ptr);
        idx   = pick[SEL_W-1:0];
        found = pick[SEL_W];
    end

endmodule

// File: rtl/tc_rr_select_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder's sel/dis inputs from registers,
// with bounded hold time per grant and a synchronous kill (force_dis).
module tc_rr_select_arbiter
    import tc_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic             force_dis,
    output logic             sel0,
    output logic             sel1,
    output logic             sel2,
    output logic             dis,
    output logic [CNT_W-1:0] hold_cnt
);

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] g_next;
    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

    // While granting, the current holder is excluded and the search starts just past it.
    always_comb begin
        g_next = sel_q + 3'd1;
        if (state == GRANT) begin
            cand     = req & ~(8'b1 << sel_q);
            pick_ptr = g_next;
        end else begin
            cand     = req;
            pick_ptr = ptr;
        end
    end

    tc_rr_pick8 u_pick (
        .mask  (cand),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            dis      <= 1'b1;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!force_dis && pick_found) begin
                        sel_q    <= pick_idx;
                        dis      <= 1'b0;
                        hold_cnt <= CNT_W'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (force_dis) begin
                        state    <= IDLE;
                        dis      <= 1'b1;
                        hold_cnt <= '0;
                        ptr      <= g_next;
                    end else if (!req[sel_q]) begin
                        ptr <= g_next;
                        if (pick_found) begin
                            sel_q    <= pick_idx;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            state    <= IDLE;
                            dis      <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                        // Timeout with no other requester re-grants the same index.
                        ptr      <= g_next;
                        hold_cnt <= CNT_W'(1);
                        if (pick_found) sel_q <= pick_idx;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel0 = sel_q[0];
    assign sel1 = sel_q[1];
    assign sel2 = sel_q[2];

endmodule

// File: tb/tb_tc_rr_select_arbiter.sv
// Self-checking bench for tc_rr_select_arbiter (MAX_HOLD=4): behavioural model feeds an
// expected queue each cycle, outputs are popped and compared after the clock edge.
module tb_tc_rr_select_arbiter;

    localparam int MH    = 4;
    localparam int CW    = $clog2(MH + 1);
    localparam int EXP_W = 1 + 3 + CW;

    logic          clk;
    logic          rst;
    logic [7:0]    req;
    logic          force_dis;
    logic          sel0, sel1, sel2, dis;
    logic [CW-1:0] hold_cnt;

    int errors = 0;
    int checks = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Reference model state
    int m_idle;
    int m_sel;
    int m_dis;
    int m_hold;
    int m_ptr;

    tc_rr_select_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .force_dis (force_dis),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .dis       (dis),
        .hold_cnt  (hold_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [7:0] mask, input int start);
        for (int k = 0; k < 8; k++) begin
            if (mask[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [7:0] rq, input logic fd);
        int p;
        int g;
        if (r) begin
            m_idle = 1; m_sel = 0; m_dis = 1; m_hold = 0; m_ptr = 0;
        end else if (m_idle == 1) begin
            if (!fd && rq != 8'h00) begin
                m_sel = model_pick(rq, m_ptr);
                m_dis = 0; m_hold = 1; m_idle = 0;
            end
        end else begin
            g = m_sel;
            if (fd) begin
                m_idle = 1; m_dis = 1; m_hold = 0; m_ptr = (g + 1) % 8;
            end else if (!rq[g]) begin
                m_ptr = (g + 1) % 8;
                p = model_pick(rq & ~(8'h01 << g), m_ptr);
                if (p >= 0) begin
                    m_sel = p; m_hold = 1;
                end else begin
                    m_idle = 1; m_dis = 1; m_hold = 0;
                end
            end else if (m_hold == MH) begin
                m_ptr = (g + 1) % 8;
                p = model_pick(rq & ~(8'h01 << g), m_ptr);
                if (p >= 0) m_sel = p;
                m_hold = 1;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver: apply one cycle of inputs, push the model's prediction, then score the DUT.
    task automatic step(input logic r, input logic [7:0] rq, input logic fd);
        logic [EXP_W-1:0] e;
        @(negedge clk);
        rst = r; req = rq; force_dis = fd;
        model_step(r, rq, fd);
        exp_q.push_back({1'(m_dis), 3'(m_sel), CW'(m_hold)});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_dis", int'(dis), int'(e[EXP_W-1]));
            check("sb_sel", int'({sel2, sel1, sel0}), int'(e[CW+2:CW]));
            check("sb_hold", int'(hold_cnt), int'(e[CW-1:0]));
        end
    endtask

    function automatic int cur_sel();
        return int'({sel2, sel1, sel0});
    endfunction

    initial begin
        rst = 1'b1; req = 8'h00; force_dis = 1'b0;

        // Reset then idle
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("idle_dis", int'(dis), 1);
            check("idle_sel", cur_sel(), 0);
            check("idle_hold", int'(hold_cnt), 0);
        end

        // Release hand-off and return to idle
        step(1'b0, 8'b0010_0100, 1'b0);
        check("first_sel", cur_sel(), 2);
        check("first_dis", int'(dis), 0);
        step(1'b0, 8'b0010_0000, 1'b0);
        check("handoff_sel", cur_sel(), 5);
        check("handoff_hold", int'(hold_cnt), 1);
        step(1'b0, 8'h00, 1'b0);
        check("release_dis", int'(dis), 1);

        // Two requesters held: rotation every MAX_HOLD cycles
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 8'h81, 1'b0);
            check("rot_sel", cur_sel(), ((i / MH) % 2 == 1) ? 7 : 0);
            check("rot_hold", int'(hold_cnt), (i % MH) + 1);
        end

        // Lone requester: re-grant on timeout, dis never rises
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h08, 1'b0);
            check("solo_sel", cur_sel(), 3);
            check("solo_dis", int'(dis), 0);
            check("solo_hold", int'(hold_cnt), (i % MH) + 1);
        end

        // force_dis during grant of 6, then pointer wraps to 0
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        check("g6_sel", cur_sel(), 6);
        step(1'b0, 8'h40, 1'b1);
        check("force_dis", int'(dis), 1);
        check("force_hold", int'(hold_cnt), 0);
        check("force_sel_kept", cur_sel(), 6);
        step(1'b0, 8'h40, 1'b1);
        check("force_dis2", int'(dis), 1);
        step(1'b0, 8'h41, 1'b0);
        check("wrap_sel", cur_sel(), 0);
        check("wrap_dis", int'(dis), 0);

        // Reset mid-grant
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h10, 1'b0);
        check("pre_rst_hold", int'(hold_cnt), 3);
        step(1'b1, 8'h10, 1'b0);
        check("mid_rst_dis", int'(dis), 1);
        check("mid_rst_sel", cur_sel(), 0);
        check("mid_rst_hold", int'(hold_cnt), 0);
        step(1'b0, 8'hFF, 1'b0);
        check("after_rst_sel", cur_sel(), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                 $urandom_range(0, 19) == 0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the sequence is bounded, this only guards against a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
